// File: rtl/mips_decode_stage.sv
// Registered MIPS decode stage: field split, immediate extension, jump target and class.
// Optional 1-entry skid buffer (registered o_ready) when DECODE_SKID_EN is defined.
module mips_decode_stage #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [31:0]       i_instr,
  input  logic [PC_W-1:0]   i_pc4,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [5:0]        o_opcode,
  output logic [4:0]        o_rs,
  output logic [4:0]        o_rt,
  output logic [4:0]        o_rd,
  output logic [4:0]        o_shamt,
  output logic [5:0]        o_funct,
  output logic [DATA_W-1:0] o_imm_ext,
  output logic [PC_W-1:0]   o_jtarget,
  output logic [PC_W-1:0]   o_pc4,
  output logic [1:0]        o_type,
  output logic              o_illegal
);

  localparam logic [1:0] TYPE_R   = 2'b00;
  localparam logic [1:0] TYPE_I   = 2'b01;
  localparam logic [1:0] TYPE_J   = 2'b10;
  localparam logic [1:0] TYPE_ILL = 2'b11;

  typedef struct packed {
    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [DATA_W-1:0] immExt;
    logic [PC_W-1:0]   jtarget;
    logic [PC_W-1:0]   pc4;
    logic [1:0]        kind;
    logic              illegal;
  } decoded_t;

  decoded_t    dec;
  logic [3:0]  pcTop;
  logic [31:0] jtWide;
  logic [15:0] imm;

  // Decode happens before the register so the next stage sees clean flop outputs.
  always_comb begin
    dec        = '0;
    imm        = i_instr[15:0];
    dec.opcode = i_instr[31:26];
    dec.rs     = i_instr[25:21];
    dec.rt     = i_instr[20:16];
    dec.rd     = i_instr[15:11];
    dec.shamt  = i_instr[10:6];
    dec.funct  = i_instr[5:0];
    dec.pc4    = i_pc4;

    case (i_instr[31:26])
      6'h0C, 6'h0D, 6'h0E: dec.immExt = DATA_W'(imm);
      6'h0F:               dec.immExt = DATA_W'($signed({imm, 16'h0000}));
      default:             dec.immExt = DATA_W'($signed(imm));
    endcase
    if (DATA_W == 16) dec.immExt = DATA_W'(imm);

    pcTop       = (PC_W == 32) ? i_pc4[PC_W-1 -: 4] : 4'h0;
    jtWide      = {pcTop, i_instr[25:0], 2'b00};
    dec.jtarget = PC_W'(jtWide);

    case (i_instr[31:26])
      6'h00:                      dec.kind = TYPE_R;
      6'h02, 6'h03:               dec.kind = TYPE_J;
      6'h04, 6'h05, 6'h08, 6'h09,
      6'h0A, 6'h0B, 6'h0C, 6'h0D,
      6'h0E, 6'h0F, 6'h20, 6'h21,
      6'h23, 6'h24, 6'h25, 6'h27,
      6'h28, 6'h29, 6'h2B:        dec.kind = TYPE_I;
      default:                    dec.kind = TYPE_ILL;
    endcase
    dec.illegal = (dec.kind == TYPE_ILL);
  end

  decoded_t outData_q, outData_d;
  logic     outValid_q, outValid_d;
  logic     accept;

`ifdef DECODE_SKID_EN
  decoded_t skidData_q, skidData_d;
  logic     skidValid_q, skidValid_d;
  logic     ready_q;
  logic     canAdvance;

  // A stalled output parks one extra word in the skid; it moves up on the next consume.
  always_comb begin
    accept      = i_valid & ready_q;
    canAdvance  = !outValid_q | i_ready;
    outData_d   = outData_q;
    outValid_d  = outValid_q;
    skidData_d  = skidData_q;
    skidValid_d = skidValid_q;
    if (i_flush) begin
      outValid_d  = 1'b0;
      skidValid_d = 1'b0;
    end else if (canAdvance) begin
      if (skidValid_q) begin
        outData_d   = skidData_q;
        outValid_d  = 1'b1;
        skidValid_d = 1'b0;
      end else if (accept) begin
        outData_d  = dec;
        outValid_d = 1'b1;
      end else begin
        outValid_d = 1'b0;
      end
    end else if (accept) begin
      skidData_d  = dec;
      skidValid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      outData_q   <= '0;
      outValid_q  <= 1'b0;
      skidData_q  <= '0;
      skidValid_q <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      outData_q   <= outData_d;
      outValid_q  <= outValid_d;
      skidData_q  <= skidData_d;
      skidValid_q <= skidValid_d;
      ready_q     <= !skidValid_d;
    end
  end

  assign o_ready = ready_q;
`else
  // A flushed edge drops the incoming word, so data only loads on an unflushed accept.
  always_comb begin
    accept     = i_valid & o_ready;
    outData_d  = outData_q;
    outValid_d = outValid_q;
    if (i_flush) begin
      outValid_d = 1'b0;
    end else if (accept) begin
      outData_d  = dec;
      outValid_d = 1'b1;
    end else if (outValid_q & i_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      outData_q  <= '0;
      outValid_q <= 1'b0;
    end else begin
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
    end
  end

  assign o_ready = !outValid_q | i_ready;
`endif

  assign o_valid   = outValid_q;
  assign o_opcode  = outData_q.opcode;
  assign o_rs      = outData_q.rs;
  assign o_rt      = outData_q.rt;
  assign o_rd      = outData_q.rd;
  assign o_shamt   = outData_q.shamt;
  assign o_funct   = outData_q.funct;
  assign o_imm_ext = outData_q.immExt;
  assign o_jtarget = outData_q.jtarget;
  assign o_pc4     = outData_q.pc4;
  assign o_type    = outData_q.kind;
  assign o_illegal = outData_q.illegal;

endmodule

// File: tb/tb_mips_decode_stage.sv
// Self-checking bench for mips_decode_stage: directed test-plan steps then random traffic
// against a queue-based model of accepted words (handles DECODE_SKID_EN as well).
module tb_mips_decode_stage;

  logic        i_clk = 1'b0;
  logic        i_rst, i_flush, i_valid, i_ready;
  logic        o_ready, o_valid, o_illegal;
  logic [31:0] i_instr, i_pc4;
  logic [5:0]  o_opcode, o_funct;
  logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
  logic [31:0] o_imm_ext, o_jtarget, o_pc4;
  logic [1:0]  o_type;

  mips_decode_stage #(.DATA_W(32), .PC_W(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready), .i_instr(i_instr), .i_pc4(i_pc4), .o_valid(o_valid),
    .i_ready(i_ready), .o_opcode(o_opcode), .o_rs(o_rs), .o_rt(o_rt),
    .o_rd(o_rd), .o_shamt(o_shamt), .o_funct(o_funct), .o_imm_ext(o_imm_ext),
    .o_jtarget(o_jtarget), .o_pc4(o_pc4), .o_type(o_type), .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } word_t;

  // pend[0] is the word on the outputs; a second entry can only exist in the skid build.
  word_t pend[$];
  word_t held;
  int    compared   = 0;
  int    mismatched = 0;

  logic [5:0] opPool [12] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h0C,
                             6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};

  function automatic logic [1:0] expType(input logic [31:0] ins);
    logic [5:0] op = ins[31:26];
    if (op == 6'h00) return 2'd0;
    if (op == 6'h02 || op == 6'h03) return 2'd2;
    if (op inside {6'h04, 6'h05, [6'h08:6'h0F], 6'h20, 6'h21, 6'h23,
                   6'h24, 6'h25, 6'h27, 6'h28, 6'h29, 6'h2B}) return 2'd1;
    return 2'd3;
  endfunction

  function automatic logic [31:0] expImm(input logic [31:0] ins);
    int         imm = int'(ins[15:0]);
    logic [5:0] op  = ins[31:26];
    if (op inside {6'h0C, 6'h0D, 6'h0E}) return 32'(imm);
    if (op == 6'h0F) return 32'(imm * 65536);
    if (imm >= 32768) return 32'(imm - 65536);
    return 32'(imm);
  endfunction

  function automatic logic [31:0] expJt(input logic [31:0] ins, input logic [31:0] pc);
    return (pc & 32'hF000_0000) | (32'(ins[25:0]) * 4);
  endfunction

  function automatic logic expReady(input logic rdy);
`ifdef DECODE_SKID_EN
    return pend.size() < 2;
`else
    return (pend.size() == 0) || rdy;
`endif
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    word_t w;
    w = (pend.size() > 0) ? pend[0] : held;
    checkVal("o_valid",   o_valid,   pend.size() > 0);
    checkVal("o_opcode",  o_opcode,  w.instr[31:26]);
    checkVal("o_rs",      o_rs,      w.instr[25:21]);
    checkVal("o_rt",      o_rt,      w.instr[20:16]);
    checkVal("o_rd",      o_rd,      w.instr[15:11]);
    checkVal("o_shamt",   o_shamt,   w.instr[10:6]);
    checkVal("o_funct",   o_funct,   w.instr[5:0]);
    checkVal("o_imm_ext", o_imm_ext, expImm(w.instr));
    checkVal("o_jtarget", o_jtarget, expJt(w.instr, w.pc4));
    checkVal("o_pc4",     o_pc4,     w.pc4);
    checkVal("o_type",    o_type,    expType(w.instr));
    checkVal("o_illegal", o_illegal, expType(w.instr) == 2'd3);
  endtask

  // One clock: drive, check o_ready before the edge, advance the model, check outputs after.
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                               input logic rdy, input logic fl);
    logic rdyExp, acc, cons;
    i_valid = v; i_instr = ins; i_pc4 = pc; i_ready = rdy; i_flush = fl;
    #3;
    rdyExp = expReady(rdy);
    checkVal("o_ready", o_ready, rdyExp);
    acc  = v && rdyExp;
    cons = (pend.size() > 0) && rdy;
    @(posedge i_clk);
    #1;
    if (fl) begin
      if (pend.size() > 0) held = pend[0];
      pend.delete();
    end else begin
      if (cons) held = pend.pop_front();
      if (acc) pend.push_back('{ins, pc});
    end
    checkOutput();
  endtask

  task automatic resetMidStream();
    i_valid = 1'b0; i_flush = 1'b0;
    #1;
    i_rst = 1'b1;
    #1;
    pend.delete();
    held = '{32'h0, 32'h0};
    checkOutput();
    checkVal("rst_o_ready", o_ready, 1'b1);
    #3;
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    logic [31:0] ins;
    held = '{32'h0, 32'h0};
    i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_instr = 32'h0; i_pc4 = 32'h0;
    #2;
    checkOutput();
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    $display("[TB] streaming LW/ADDI/ANDI");
    applyStimulus(1'b1, 32'h8C43_0004, 32'h0000_1004, 1'b1, 1'b0);
    checkVal("lw_type", o_type, 2'b01);
    checkVal("lw_imm", o_imm_ext, 32'h0000_0004);
    applyStimulus(1'b1, 32'h2062_FFFF, 32'h0000_1008, 1'b1, 1'b0);
    checkVal("addi_imm", o_imm_ext, 32'hFFFF_FFFF);
    checkVal("addi_valid", o_valid, 1'b1);
    applyStimulus(1'b1, 32'h3062_FFFF, 32'h0000_100C, 1'b1, 1'b0);
    checkVal("andi_imm", o_imm_ext, 32'h0000_FFFF);

    $display("[TB] jump, LUI and illegal");
    applyStimulus(1'b1, 32'h0BFF_FFFF, 32'hA000_0010, 1'b1, 1'b0);
    checkVal("j_type", o_type, 2'b10);
    checkVal("j_target", o_jtarget, 32'hAFFF_FFFC);
    applyStimulus(1'b1, 32'h3C01_1234, 32'h0000_2000, 1'b1, 1'b0);
    checkVal("lui_imm", o_imm_ext, 32'h1234_0000);
    applyStimulus(1'b1, 32'hFC00_0000, 32'h0000_2004, 1'b1, 1'b0);
    checkVal("ill_type", o_type, 2'b11);
    checkVal("ill_flag", o_illegal, 1'b1);
    checkVal("ill_valid", o_valid, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkVal("drain_valid", o_valid, 1'b0);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 32'h2001_0011, 32'h0000_3000, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++)
      applyStimulus(1'b1, 32'h2001_0020 + 32'(k), 32'h0000_3004 + 32'(4 * k), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("[TB] asynchronous reset mid-stream");
    applyStimulus(1'b1, 32'h8C43_0004, 32'h0000_4000, 1'b0, 1'b0);
    checkVal("pre_rst_valid", o_valid, 1'b1);
    resetMidStream();
    checkVal("post_rst_valid", o_valid, 1'b0);

    $display("[TB] flush");
    applyStimulus(1'b1, 32'h0022_1820, 32'h0000_5000, 1'b1, 1'b1);
    checkVal("flush_valid", o_valid, 1'b0);
    applyStimulus(1'b1, 32'h0022_1820, 32'h0000_5004, 1'b1, 1'b0);
    checkVal("r_rs", o_rs, 5'd1);
    checkVal("r_rt", o_rt, 5'd2);
    checkVal("r_rd", o_rd, 5'd3);
    checkVal("r_funct", o_funct, 6'h20);
    checkVal("r_type", o_type, 2'b00);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) ins[31:26] = opPool[$urandom_range(0, 11)];
      applyStimulus($urandom_range(0, 3) != 0, ins, $urandom,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
